// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector for the ID stage of a 5-stage MIPS pipeline, with a saturating stall counter.
// Optional build macro: HAZARD_ZERO_REG_FILTER_EN (a load into $zero never stalls).
module hazard_detection_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  IDEXMemRead,
    input  logic [REG_ADDR_W-1:0] IDEXrt,
    input  logic [REG_ADDR_W-1:0] IFIDrs,
    input  logic [REG_ADDR_W-1:0] IFIDrt,
    output logic                  MuxSig,
    output logic                  IFIDWrite,
    output logic                  PCWrite,
    output logic [CNT_W-1:0]      StallCount,
    output logic                  StallQ
);

    logic regMatch;
    logic destValid;
    logic hazard;

    assign regMatch = (IDEXrt == IFIDrs) || (IDEXrt == IFIDrt);

`ifdef HAZARD_ZERO_REG_FILTER_EN
    assign destValid = (IDEXrt != '0);
`else
    assign destValid = 1'b1;
`endif

    // Reset gates the decision so the pipeline is never frozen while in reset.
    assign hazard = Rst_n && IDEXMemRead && regMatch && destValid;

    assign MuxSig    = hazard;
    assign IFIDWrite = ~hazard;
    assign PCWrite   = ~hazard;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            StallCount <= '0;
            StallQ     <= 1'b0;
        end else begin
            StallQ <= hazard;
            // Counter sticks at all-ones instead of wrapping.
            if (hazard && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a default instance and a 2-bit-counter instance share stimulus.
module tb_hazard_detection_unit;

    logic       Clk;
    logic       Rst_n;
    logic       IDEXMemRead;
    logic [4:0] IDEXrt;
    logic [4:0] IFIDrs;
    logic [4:0] IFIDrt;

    logic        muxSig, ifidWrite, pcWrite, stallQ;
    logic [31:0] stallCount;
    logic        muxSig2, ifidWrite2, pcWrite2, stallQ2;
    logic [1:0]  stallCount2;

    int vectors     = 0;
    int miscompares = 0;
    int expCnt      = 0;
    int expCnt2     = 0;
    logic expHz     = 1'b0;
    logic zeroHz;

    hazard_detection_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IDEXMemRead(IDEXMemRead), .IDEXrt(IDEXrt),
        .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .MuxSig(muxSig), .IFIDWrite(ifidWrite),
        .PCWrite(pcWrite), .StallCount(stallCount), .StallQ(stallQ)
    );

    hazard_detection_unit #(.REG_ADDR_W(5), .CNT_W(2)) dutSat (
        .Clk(Clk), .Rst_n(Rst_n), .IDEXMemRead(IDEXMemRead), .IDEXrt(IDEXrt),
        .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .MuxSig(muxSig2), .IFIDWrite(ifidWrite2),
        .PCWrite(pcWrite2), .StallCount(stallCount2), .StallQ(stallQ2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input vector away from the clock edge and check the combinational response.
    task automatic apply(input logic rst, input logic ld, input logic [4:0] drt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic hz);
        Rst_n = rst; IDEXMemRead = ld; IDEXrt = drt; IFIDrs = rs; IFIDrt = rt;
        expHz = hz;
        #1;
        check("MuxSig", {31'd0, muxSig}, {31'd0, hz});
        check("IFIDWrite", {31'd0, ifidWrite}, {31'd0, ~hz});
        check("PCWrite", {31'd0, pcWrite}, {31'd0, ~hz});
        check("MuxSig_sat", {31'd0, muxSig2}, {31'd0, hz});
    endtask

    // Advance one edge and check the registered state of both instances.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (!Rst_n) begin
            expCnt  = 0;
            expCnt2 = 0;
        end else if (expHz) begin
            expCnt++;
            if (expCnt2 < 3) expCnt2++;
        end
        check("StallQ", {31'd0, stallQ}, {31'd0, expHz & Rst_n});
        check("StallCount", stallCount, expCnt);
        check("StallCount_sat", {30'd0, stallCount2}, expCnt2);
        check("StallQ_sat", {31'd0, stallQ2}, {31'd0, expHz & Rst_n});
    endtask

    initial begin
`ifdef HAZARD_ZERO_REG_FILTER_EN
        zeroHz = 1'b0;
`else
        zeroHz = 1'b1;
`endif
        // Reset with a would-be hazard: outputs must stay released.
        apply(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        tick();
        tick();

        // All-zero registers: stall depends on the zero-register filter.
        apply(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, zeroHz);
        tick();
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Load with no register match.
        apply(1'b1, 1'b1, 5'd16, 5'd8, 5'd4, 1'b0);
        tick();

        // Match on rs only, then rt only, then both.
        apply(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
        tick();
        apply(1'b1, 1'b1, 5'd4, 5'd8, 5'd4, 1'b1);
        tick();
        apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
        tick();

        // Non-load with matching registers never stalls.
        apply(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0);
        tick();

        // Hold a hazard for three edges, then reset mid-stall.
        apply(1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        apply(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0);
        tick();

        // Saturation of the 2-bit counter after five hazard edges.
        apply(1'b1, 1'b1, 5'd12, 5'd12, 5'd2, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("SatFinal", {30'd0, stallCount2}, 32'd3);
        check("WideFinal", stallCount, 32'd5);

        apply(1'b1, 1'b0, 5'd12, 5'd12, 5'd2, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Load-use hazard detector for the classic 5-stage MIPS pipeline; sits in the ID stage.
- Compares the destination register of a load in ID/EX against the source registers of the instruction in IF/ID.
- On a match it stalls PC and IF/ID and selects the bubble (zeroed control) mux for one cycle.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- IDEXMemRead  input  1  instruction in ID/EX is a load.
- IDEXrt  input  REG_ADDR_W  load destination register in ID/EX.
- IFIDrs  input  REG_ADDR_W  rs field of the instruction in IF/ID.
- IFIDrt  input  REG_ADDR_W  rt field of the instruction in IF/ID.
- MuxSig  output  1  1 = drive zeroed control into ID/EX (bubble); 0 = normal control.
- IFIDWrite  output  1  IF/ID register write enable; 0 = hold.
- PCWrite  output  1  PC write enable; 0 = hold.
- StallCount  output  CNT_W  registered count of stall cycles since reset.
- StallQ  output  1  registered copy of the hazard decision from the previous cycle.

Behaviour:
- hazard = IDEXMemRead AND ((IDEXrt == IFIDrs) OR (IDEXrt == IFIDrt)), subject to the Optional Feature.
- Outputs are combinational in the current cycle, with zero latency:
  - MuxSig = hazard
  - IFIDWrite = NOT hazard
  - PCWrite = NOT hazard
- Fixed invariant: IFIDWrite == PCWrite == NOT MuxSig at all times.
- While Rst_n = 0, hazard is forced to 0, regardless of the other inputs:
  - MuxSig = 0, IFIDWrite = 1, PCWrite = 1
  - The pipeline must never be frozen in reset.
- Rising edge of Clk with Rst_n = 0: StallCount <= 0, StallQ <= 0.
- Rising edge of Clk with Rst_n = 1:
  - StallQ <= hazard.
  - If hazard, StallCount <= StallCount + 1.
  - StallCount saturates at all-ones and does not wrap.
- No stall duration is tracked internally.
- The one-cycle stall ends naturally: the inserted bubble clears IDEXMemRead on the next cycle.
- If the inputs still match next cycle, the block stalls again; it is purely input-driven.
- Reset asserted mid-stall:
  - Outputs release immediately (combinational gating).
  - State clears on the next edge.
- Outputs must be glitch-free with respect to X: unknown inputs are not required to resolve. The bench drives only known values.
- IFIDrs and IFIDrt matching simultaneously gives a single stall with identical outputs; the counter increments once per cycle.
- IDEXMemRead = 0 gives no hazard, regardless of register equality.

Optional Feature:
- Macro: HAZARD_ZERO_REG_FILTER_EN.
- Defined: a load to register 0 never causes a hazard ($zero is hardwired), i.e. hazard additionally requires IDEXrt != 0.
- Not defined: pure equality compare; IDEXrt = 0 matching rs/rt of 0 does stall.

Test Plan:
- Rst_n=0 with IDEXMemRead=1, IDEXrt=3, IFIDrs=3 -> MuxSig=0, IFIDWrite=1, PCWrite=1; after an edge, StallCount=0 and StallQ=0.
- Rst_n=1, IDEXMemRead=1, IDEXrt=IFIDrs=IFIDrt=0 -> stall (MuxSig=1, IFIDWrite=0, PCWrite=0) without the macro; no stall with HAZARD_ZERO_REG_FILTER_EN. Then IDEXMemRead=0 with all registers 0 -> MuxSig=0, IFIDWrite=1, PCWrite=1 in both builds.
- IDEXMemRead=1, IDEXrt=16, IFIDrs=8, IFIDrt=4 -> no stall; StallCount unchanged across the edge.
- IDEXMemRead=1, IDEXrt=3, IFIDrs=3, IFIDrt=0 -> MuxSig=1, IFIDWrite=0, PCWrite=0; next edge StallQ=1 and StallCount +1. Repeat with the match on IFIDrt only (IDEXrt=4, IFIDrs=8, IFIDrt=4) -> same response.
- Hold the matching inputs for 3 edges -> StallCount +3. Then assert Rst_n=0 mid-stall -> outputs release in the same cycle; next edge StallCount=0.
- With CNT_W=2, hold the hazard for 5 edges -> StallCount saturates at 3.
